reg_id_ex: RTL and testbench
============================

Name: reg_id_ex

Overview:
- ID/EX pipeline register for the MIPS datapath.
- Sits directly downstream of the main control decoder and the register file.
- Captures the decoder's control word with the decode-stage operands each cycle, supports stall (hold) and flush (bubble), and flags unsupported opcodes.
- Recovers the branch kind from op_code, because the decoder drives an identical `branch` for beq/bne/bgtz.

Parameters:
- DATA_W, 32, width of PC and operand datapaths
- CNT_W, 16, width of the saturating bubble counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- stall  in  1  hold current contents
- flush  in  1  replace next contents with a bubble
- id_valid  in  1  decode stage holds a real instruction
- op_code  in  6  instruction[31:26]
- branch, memRead, memWrite, aluSrc, regWrite, memToReg, regDst  in  1 each  decoder control bits
- aluOp  in  3  decoder ALU op class
- pc_plus4  in  DATA_W  PC+4 of the decode instruction
- read_data1, read_data2  in  DATA_W  register file outputs
- sign_ext_imm  in  DATA_W  sign-extended immediate (funct = [5:0])
- rs, rt, rd  in  5 each  register specifiers
- ex_valid  out  1  EX holds a real instruction
- ex_branch, ex_memRead, ex_memWrite, ex_aluSrc, ex_regWrite, ex_memToReg, ex_regDst  out  1 each  registered control
- ex_aluOp  out  3  registered ALU op class
- ex_branch_type  out  2  00 none, 01 beq, 10 bne, 11 bgtz
- ex_illegal  out  1  captured instruction had an unsupported opcode
- ex_pc_plus4, ex_rd1, ex_rd2, ex_imm  out  DATA_W each  registered operands
- ex_rs, ex_rt, ex_rd  out  5 each  registered specifiers
- bubble_count  out  CNT_W  saturating count of bubbles inserted

Behaviour:
- All state updates on the rising edge of clk. Latency is 1 cycle (inputs at edge N appear at outputs after edge N).
- Priority per edge: reset > flush > stall > load.
- Reset (rst_n=0 at edge): every output is 0, including bubble_count and ex_aluOp=000. Reset mid-stall or mid-flush wins unconditionally.
- Supported opcodes: 000000, 100011, 101011, 000100, 000101, 000111, 001000, 001100, 001101, 001010.
- Load (flush=0, stall=0, id_valid=1, supported opcode):
  - All ex_* fields take their inputs; ex_valid=1; ex_illegal=0.
  - ex_branch_type: 01 for 000100, 10 for 000101, 11 for 000111, else 00.
- Sanitizing on load, so that no X from decoder don't-cares enters the pipeline:
  - When regWrite=0, ex_memToReg=0 and ex_regDst=0 regardless of inputs.
  - When branch=0, ex_branch_type=00.
- Illegal load (flush=0, stall=0, id_valid=1, unsupported opcode):
  - Bubble is loaded (see below) except ex_illegal=1 and ex_pc_plus4 captured.
  - bubble_count increments.
- Bubble (flush=1, or load with id_valid=0):
  - ex_valid=0; all control outputs 0; ex_aluOp=000; ex_branch_type=00; ex_illegal=0.
  - Data/specifier outputs are cleared to 0.
  - bubble_count increments.
- Stall (flush=0, stall=1): all outputs hold, including ex_illegal; bubble_count holds.
- Flush and stall together: flush wins, and a bubble is inserted.
- bubble_count saturates at 2^CNT_W-1 and never wraps.
- Control inputs are ignored whenever id_valid=0 or flush=1. X on them must then not reach any output.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with stall=1, flush=1 -> all outputs 0, bubble_count=0.
- R-type load: op_code=000000, regWrite=1, regDst=1, aluOp=010, rd1=0x5, rd2=0x7, rd=9, id_valid=1 -> next cycle ex_valid=1, ex_aluOp=010, ex_regDst=1, ex_rd1=0x5, ex_rd=9, ex_branch_type=00.
- Branch decode: op_code 000100 / 000101 / 000111 with branch=1 on consecutive cycles -> ex_branch_type 01 / 10 / 11.
- Sanitize: sw (op_code=101011, regWrite=0, memToReg=x, regDst=x) -> ex_memWrite=1, ex_memToReg=0, ex_regDst=0, no X on any output.
- Stall/flush: load lw, then stall=1 for 3 cycles -> outputs unchanged. Then stall=1 with flush=1 -> bubble with ex_valid=0, bubble_count=1.
- Illegal and saturation:
  - op_code=111111, id_valid=1 -> ex_illegal=1, ex_valid=0, ex_regWrite=0.
  - With CNT_W=2, 5 consecutive flushes -> bubble_count stops at 3.

Source files
------------

// File: rtl/reg_id_ex.sv
// ID/EX pipeline register: captures the decoder control word and decode-stage
// operands, with stall (hold), flush (bubble), illegal-opcode flagging, branch
// kind recovery from op_code and a saturating bubble counter.
module reg_id_ex #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [5:0]        op_code,
  input  logic              branch,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              aluSrc,
  input  logic              regWrite,
  input  logic              memToReg,
  input  logic              regDst,
  input  logic [2:0]        aluOp,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  input  logic [DATA_W-1:0] sign_ext_imm,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  output logic              ex_valid,
  output logic              ex_branch,
  output logic              ex_memRead,
  output logic              ex_memWrite,
  output logic              ex_aluSrc,
  output logic              ex_regWrite,
  output logic              ex_memToReg,
  output logic              ex_regDst,
  output logic [2:0]        ex_aluOp,
  output logic [1:0]        ex_branch_type,
  output logic              ex_illegal,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [CNT_W-1:0]  bubble_count
);

  logic       isSupported;
  logic [1:0] branchType;
  logic       loadValid;
  logic       loadIllegal;
  logic       update;
  logic       bubbleEvent;
  logic       keepCtrl;

  // Opcode decode: which opcodes are supported, and the branch kind the
  // decoder's shared branch bit cannot tell apart. Unknown opcodes fall to
  // the default arm, so X on op_code never claims to be supported.
  always_comb begin
    isSupported = 1'b0;
    branchType  = 2'b00;
    case (op_code)
      6'b000000, 6'b100011, 6'b101011, 6'b001000,
      6'b001100, 6'b001101, 6'b001010: isSupported = 1'b1;
      6'b000100: begin isSupported = 1'b1; branchType = 2'b01; end
      6'b000101: begin isSupported = 1'b1; branchType = 2'b10; end
      6'b000111: begin isSupported = 1'b1; branchType = 2'b11; end
      default: ;
    endcase
  end

  // Next-cycle qualifiers. Every control/data input is ANDed with loadValid,
  // so X on decoder outputs during a bubble resolves to 0 instead of leaking.
  always_comb begin
    update      = flush | ~stall;
    loadValid   = ~flush & id_valid & isSupported;
    loadIllegal = ~flush & id_valid & ~isSupported;
    bubbleEvent = update & ~loadValid;
    keepCtrl    = loadValid;
  end

  // Pipeline register: reset > flush > stall > load; bubbles clear everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid       <= 1'b0;
      ex_branch      <= 1'b0;
      ex_memRead     <= 1'b0;
      ex_memWrite    <= 1'b0;
      ex_aluSrc      <= 1'b0;
      ex_regWrite    <= 1'b0;
      ex_memToReg    <= 1'b0;
      ex_regDst      <= 1'b0;
      ex_aluOp       <= '0;
      ex_branch_type <= '0;
      ex_illegal     <= 1'b0;
      ex_pc_plus4    <= '0;
      ex_rd1         <= '0;
      ex_rd2         <= '0;
      ex_imm         <= '0;
      ex_rs          <= '0;
      ex_rt          <= '0;
      ex_rd          <= '0;
    end else if (update) begin
      ex_valid       <= keepCtrl;
      ex_branch      <= keepCtrl & branch;
      ex_memRead     <= keepCtrl & memRead;
      ex_memWrite    <= keepCtrl & memWrite;
      ex_aluSrc      <= keepCtrl & aluSrc;
      ex_regWrite    <= keepCtrl & regWrite;
      ex_memToReg    <= keepCtrl & regWrite & memToReg;
      ex_regDst      <= keepCtrl & regWrite & regDst;
      ex_aluOp       <= {3{keepCtrl}} & aluOp;
      ex_branch_type <= {2{keepCtrl & branch}} & branchType;
      ex_illegal     <= loadIllegal;
      ex_pc_plus4    <= {DATA_W{keepCtrl | loadIllegal}} & pc_plus4;
      ex_rd1         <= {DATA_W{keepCtrl}} & read_data1;
      ex_rd2         <= {DATA_W{keepCtrl}} & read_data2;
      ex_imm         <= {DATA_W{keepCtrl}} & sign_ext_imm;
      ex_rs          <= {5{keepCtrl}} & rs;
      ex_rt          <= {5{keepCtrl}} & rt;
      ex_rd          <= {5{keepCtrl}} & rd;
    end
  end

  // Saturating count of inserted bubbles (flushes, empty slots, illegal ops).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_count <= '0;
    end else if (bubbleEvent && (bubble_count != '1)) begin
      bubble_count <= bubble_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_id_ex.sv
// Directed bench for reg_id_ex, built with a 2-bit bubble counter so that
// saturation is reachable in a handful of cycles.
module tb_reg_id_ex;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 2;

  logic clk = 1'b0;
  logic rst_n, stall, flush, id_valid;
  logic [5:0] op_code;
  logic branch, memRead, memWrite, aluSrc, regWrite, memToReg, regDst;
  logic [2:0] aluOp;
  logic [DATA_W-1:0] pc_plus4, read_data1, read_data2, sign_ext_imm;
  logic [4:0] rs, rt, rd;
  logic ex_valid, ex_branch, ex_memRead, ex_memWrite, ex_aluSrc, ex_regWrite;
  logic ex_memToReg, ex_regDst, ex_illegal;
  logic [2:0] ex_aluOp;
  logic [1:0] ex_branch_type;
  logic [DATA_W-1:0] ex_pc_plus4, ex_rd1, ex_rd2, ex_imm;
  logic [4:0] ex_rs, ex_rt, ex_rd;
  logic [CNT_W-1:0] bubble_count;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  reg_id_ex #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .op_code(op_code), .branch(branch), .memRead(memRead), .memWrite(memWrite),
    .aluSrc(aluSrc), .regWrite(regWrite), .memToReg(memToReg), .regDst(regDst),
    .aluOp(aluOp), .pc_plus4(pc_plus4), .read_data1(read_data1),
    .read_data2(read_data2), .sign_ext_imm(sign_ext_imm), .rs(rs), .rt(rt), .rd(rd),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_memRead(ex_memRead),
    .ex_memWrite(ex_memWrite), .ex_aluSrc(ex_aluSrc), .ex_regWrite(ex_regWrite),
    .ex_memToReg(ex_memToReg), .ex_regDst(ex_regDst), .ex_aluOp(ex_aluOp),
    .ex_branch_type(ex_branch_type), .ex_illegal(ex_illegal),
    .ex_pc_plus4(ex_pc_plus4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .bubble_count(bubble_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setCtrl(input logic [5:0] op, input logic br, input logic mr,
                         input logic mw, input logic as, input logic rw,
                         input logic m2r, input logic rdst, input logic [2:0] aop);
    op_code = op; branch = br; memRead = mr; memWrite = mw; aluSrc = as;
    regWrite = rw; memToReg = m2r; regDst = rdst; aluOp = aop;
  endtask

  task automatic setCtrlX();
    op_code = 'x; branch = 'x; memRead = 'x; memWrite = 'x; aluSrc = 'x;
    regWrite = 'x; memToReg = 'x; regDst = 'x; aluOp = 'x;
    pc_plus4 = 'x; read_data1 = 'x; read_data2 = 'x; sign_ext_imm = 'x;
    rs = 'x; rt = 'x; rd = 'x;
  endtask

  function automatic logic anyX();
    return $isunknown({ex_valid, ex_branch, ex_memRead, ex_memWrite, ex_aluSrc,
                       ex_regWrite, ex_memToReg, ex_regDst, ex_aluOp, ex_branch_type,
                       ex_illegal, ex_pc_plus4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt,
                       ex_rd, bubble_count});
  endfunction

  initial begin
    // Reset held two edges with stall and flush asserted and junk on the inputs.
    rst_n = 1'b0; stall = 1'b1; flush = 1'b1; id_valid = 1'b1;
    setCtrl(6'b000000, 1, 1, 1, 1, 1, 1, 1, 3'b111);
    pc_plus4 = 32'hFFFF_FFFF; read_data1 = 32'h1234; read_data2 = 32'h5678;
    sign_ext_imm = 32'h9ABC; rs = 5'd1; rt = 5'd2; rd = 5'd3;
    tick(); tick();
    check("rst_valid", ex_valid, 0);
    check("rst_ctrl", {ex_branch, ex_memRead, ex_memWrite, ex_aluSrc, ex_regWrite,
                       ex_memToReg, ex_regDst, ex_illegal}, 0);
    check("rst_aluOp", ex_aluOp, 0);
    check("rst_data", {ex_pc_plus4, ex_rd1}, 0);
    check("rst_spec", {ex_rs, ex_rt, ex_rd, ex_branch_type}, 0);
    check("rst_bubbles", bubble_count, 0);

    // R-type load.
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b1;
    setCtrl(6'b000000, 0, 0, 0, 0, 1, 0, 1, 3'b010);
    pc_plus4 = 32'h104; read_data1 = 32'h5; read_data2 = 32'h7;
    sign_ext_imm = 32'h20; rs = 5'd4; rt = 5'd6; rd = 5'd9;
    tick();
    check("r_valid", ex_valid, 1);
    check("r_aluOp", ex_aluOp, 3'b010);
    check("r_regDst", ex_regDst, 1);
    check("r_regWrite", ex_regWrite, 1);
    check("r_rd1", ex_rd1, 32'h5);
    check("r_rd2", ex_rd2, 32'h7);
    check("r_pc", ex_pc_plus4, 32'h104);
    check("r_spec", {ex_rs, ex_rt, ex_rd}, {5'd4, 5'd6, 5'd9});
    check("r_btype", ex_branch_type, 2'b00);
    check("r_illegal", ex_illegal, 0);

    // Branch kinds on consecutive cycles.
    setCtrl(6'b000100, 1, 0, 0, 0, 0, 0, 0, 3'b001); tick();
    check("beq_type", ex_branch_type, 2'b01);
    check("beq_branch", ex_branch, 1);
    setCtrl(6'b000101, 1, 0, 0, 0, 0, 0, 0, 3'b001); tick();
    check("bne_type", ex_branch_type, 2'b10);
    setCtrl(6'b000111, 1, 0, 0, 0, 0, 0, 0, 3'b001); tick();
    check("bgtz_type", ex_branch_type, 2'b11);
    // Branch opcode but branch bit low: kind must be cleared.
    setCtrl(6'b000100, 0, 0, 0, 0, 0, 0, 0, 3'b001); tick();
    check("nobr_type", ex_branch_type, 2'b00);

    // sw with don't-care memToReg/regDst.
    setCtrl(6'b101011, 0, 0, 1, 1, 0, 1'bx, 1'bx, 3'b000); tick();
    check("sw_memWrite", ex_memWrite, 1);
    check("sw_memToReg", ex_memToReg, 0);
    check("sw_regDst", ex_regDst, 0);
    check("sw_noX", anyX(), 0);

    // lw, then three stalled cycles with changing inputs.
    setCtrl(6'b100011, 0, 1, 0, 1, 1, 1, 0, 3'b000);
    pc_plus4 = 32'h300; read_data1 = 32'h100; read_data2 = 32'h0;
    sign_ext_imm = 32'h8; rs = 5'd8; rt = 5'd5; rd = 5'd0;
    tick();
    check("lw_memRead", ex_memRead, 1);
    check("lw_memToReg", ex_memToReg, 1);
    check("lw_imm", ex_imm, 32'h8);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      setCtrl(6'b000000, 1, 0, 1, 0, 0, 0, 1, 3'b110);
      pc_plus4 = 32'hAA0 + i; read_data1 = 32'hDEAD + i; sign_ext_imm = 32'hF0 + i;
      tick();
      check("stall_rd1", ex_rd1, 32'h100);
      check("stall_ctrl", {ex_valid, ex_memRead, ex_memToReg, ex_memWrite, ex_aluOp},
            {1'b1, 1'b1, 1'b1, 1'b0, 3'b000});
      check("stall_pc", ex_pc_plus4, 32'h300);
      check("stall_bubbles", bubble_count, 0);
    end

    // Stall and flush together, X on every decoder input: bubble.
    flush = 1'b1; setCtrlX(); tick();
    check("flush_valid", ex_valid, 0);
    check("flush_bubbles", bubble_count, 1);
    check("flush_data", {ex_rd1, ex_pc_plus4, ex_memRead}, 0);
    check("flush_noX", anyX(), 0);

    // Illegal opcode.
    flush = 1'b0; stall = 1'b0; id_valid = 1'b1;
    setCtrl(6'b111111, 0, 1, 0, 1, 1, 1, 1, 3'b101);
    pc_plus4 = 32'h200; read_data1 = 32'h77; rd = 5'd12;
    tick();
    check("ill_flag", ex_illegal, 1);
    check("ill_valid", ex_valid, 0);
    check("ill_regWrite", ex_regWrite, 0);
    check("ill_pc", ex_pc_plus4, 32'h200);
    check("ill_rd1", ex_rd1, 0);
    check("ill_bubbles", bubble_count, 2);
    stall = 1'b1; setCtrl(6'b000000, 0, 0, 0, 0, 1, 0, 1, 3'b010); tick();
    check("ill_hold", ex_illegal, 1);
    check("ill_hold_bubbles", bubble_count, 2);

    // Empty decode slot with X on controls.
    stall = 1'b0; id_valid = 1'b0; setCtrlX(); tick();
    check("idle_valid_illegal", {ex_valid, ex_illegal}, 0);
    check("idle_noX", anyX(), 0);
    check("idle_bubbles", bubble_count, 3);

    // Reset mid-flush, then five flushes saturate the 2-bit counter.
    rst_n = 1'b0; flush = 1'b1; stall = 1'b1; tick();
    check("rst2_bubbles", bubble_count, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("sat_bubbles", bubble_count, (i < 3) ? i + 1 : 3);
    end

    // Recovery: ordinary load after the flush train.
    flush = 1'b0; stall = 1'b0; id_valid = 1'b1;
    setCtrl(6'b001000, 0, 0, 0, 1, 1, 0, 0, 3'b000);
    pc_plus4 = 32'h404; read_data1 = 32'h11; read_data2 = 32'h22;
    sign_ext_imm = 32'hFFFF_FFFC; rs = 5'd2; rt = 5'd3; rd = 5'd4;
    tick();
    check("addi_valid", ex_valid, 1);
    check("addi_imm", ex_imm, 32'hFFFF_FFFC);
    check("addi_bubbles", bubble_count, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
